// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host byte stream and core memory-load port bundle for prog_loader
//
// Purpose : groups the host byte handshake and the core memory-load bus.
// Signals : in_valid/in_data/in_ready - host byte handshake (transfer when both high)
//           ld_addr/ld_data/ld_we     - memory write port toward the core
// Modports: slave  - loader side (consumes bytes, drives the load port)
//           master - host/observer side
interface prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_we;

    modport slave (
        input  in_valid, in_data,
        output in_ready, ld_addr, ld_data, ld_we
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, ld_addr, ld_data, ld_we
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader driving the core load port and core reset
//
// Purpose : parses frames HDR, A, N, N payload bytes, C from a host byte stream,
//           writes the payload to core memory starting at A, verifies the 8-bit
//           wrapping checksum C == A + N + sum(payload), then releases the core.
// Ports   : clk      - system clock, rising edge
//           rst      - synchronous active-high reset
//           bus      - prog_loader_if.slave: in_valid/in_data/in_ready byte stream,
//                      ld_addr/ld_data/ld_we memory write port
//           core_rst - high holds the core in reset
//           busy     - frame in progress (ADDR..RELEASE)
//           done     - one-cycle pulse after a good checksum
//           err      - last frame failed its checksum; cleared by the next HDR
module prog_loader #(
    parameter int                ADDR_W = 8,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] HDR    = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_CSUM    = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;
    localparam logic [2:0] S_RUN     = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] acc;
    logic              ld_we_q;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [DATA_W-1:0] ld_data_q;

    logic              accept;
    logic              is_hdr;
    logic [DATA_W-1:0] acc_nxt;

    assign accept  = bus.in_valid && bus.in_ready;
    assign is_hdr  = (bus.in_data == HDR);
    assign acc_nxt = acc + bus.in_data;

    // Every status output is a pure function of the state: RELEASE is the
    // single done cycle, ERROR is the only place err is seen, and the core is
    // held in reset everywhere but RUN. Entering ADDR from RUN therefore
    // re-asserts core_rst on the cycle after the HDR is taken, and leaving
    // ERROR on an HDR clears err.
    assign bus.in_ready = (state != S_RELEASE);
    assign done         = (state == S_RELEASE);
    assign err          = (state == S_ERROR);
    assign core_rst     = (state != S_RUN);
    assign busy         = (state == S_ADDR) || (state == S_LEN) || (state == S_DATA) ||
                          (state == S_CSUM) || (state == S_RELEASE);

    assign bus.ld_we   = ld_we_q;
    assign bus.ld_addr = ld_addr_q;
    assign bus.ld_data = ld_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            cnt       <= '0;
            acc       <= '0;
            ld_we_q   <= 1'b0;
            ld_addr_q <= '0;
            ld_data_q <= '0;
        end else begin
            // Write strobe is a single-cycle pulse per payload byte; address
            // and data simply hold between strobes.
            ld_we_q <= 1'b0;
            if (state == S_RELEASE) begin
                state <= S_RUN;
            end else if (accept) begin
                case (state)
                    S_IDLE, S_RUN, S_ERROR: begin
                        if (is_hdr) begin
                            state <= S_ADDR;
                            acc   <= '0;
                        end
                    end
                    S_ADDR: begin
                        addr  <= ADDR_W'(bus.in_data);
                        acc   <= acc_nxt;
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        cnt   <= bus.in_data;
                        acc   <= acc_nxt;
                        state <= (bus.in_data == '0) ? S_CSUM : S_DATA;
                    end
                    S_DATA: begin
                        ld_we_q   <= 1'b1;
                        ld_addr_q <= addr;
                        ld_data_q <= bus.in_data;
                        addr      <= addr + ADDR_W'(1);
                        acc       <= acc_nxt;
                        cnt       <= cnt - DATA_W'(1);
                        if (cnt == DATA_W'(1)) begin
                            state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        state <= (bus.in_data == acc) ? S_RELEASE : S_ERROR;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    logic clk = 1'b0;
    logic rst;
    logic core_rst, busy, done, err;

    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HDR(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // exp = {ld_we, ld_addr, ld_data, in_ready, core_rst, busy, done, err}
    typedef struct packed {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic [21:0] exp;
    } vec_t;

    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] wr_q[$];
    int          done_cnt = 0;
    bit          mon_en = 1'b0;

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic we, input logic [7:0] a, input logic [7:0] dd,
                                input logic [4:0] flags);
        vec_t t;
        t.r   = r;
        t.v   = v;
        t.d   = d;
        t.exp = {we, a, dd, flags};
        return t;
    endfunction

    function automatic logic [21:0] obs();
        return {bus.ld_we, bus.ld_addr, bus.ld_data, bus.in_ready, core_rst, busy, done, err};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Write capture, done counting, and in_ready low exactly in the release cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ld_we) wr_q.push_back({bus.ld_addr, bus.ld_data});
            if (done) done_cnt++;
            n_cmp++;
            if (bus.in_ready !== !done) begin
                n_bad++;
                $display("FAIL ready_vs_release: in_ready %b, done %b", bus.in_ready, done);
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input int gap);
        logic taken;
        taken = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 8 && !taken; k++) begin
            taken = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!taken) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: byte %h not accepted, required acceptance", d);
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  good[9];
        logic [15:0] exp_wr[5];
        int          k;

        good   = '{8'hA5, 8'h00, 8'h05, 8'h20, 8'h1F, 8'h30, 8'h34, 8'h60, 8'h08};
        exp_wr = '{16'h0020, 16'h011F, 16'h0230, 16'h0334, 16'h0460};

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // flags = {in_ready, core_rst, busy, done, err}
        // idle 11000, frame 11100, release 01110, run 10000, error 11001
        tbl.push_back(mk(H, L, 8'h00, L, 8'h00, 8'h00, 5'b11000));
        // good load
        tbl.push_back(mk(L, H, 8'hA5, L, 8'h00, 8'h00, 5'b11100));
        tbl.push_back(mk(L, H, 8'h00, L, 8'h00, 8'h00, 5'b11100));
        tbl.push_back(mk(L, H, 8'h05, L, 8'h00, 8'h00, 5'b11100));
        tbl.push_back(mk(L, H, 8'h20, H, 8'h00, 8'h20, 5'b11100));
        tbl.push_back(mk(L, H, 8'h1F, H, 8'h01, 8'h1F, 5'b11100));
        tbl.push_back(mk(L, H, 8'h30, H, 8'h02, 8'h30, 5'b11100));
        tbl.push_back(mk(L, H, 8'h34, H, 8'h03, 8'h34, 5'b11100));
        tbl.push_back(mk(L, H, 8'h60, H, 8'h04, 8'h60, 5'b11100));
        tbl.push_back(mk(L, H, 8'h08, L, 8'h04, 8'h60, 5'b01110));
        // HDR offered during release is not taken; core runs
        tbl.push_back(mk(L, H, 8'hA5, L, 8'h04, 8'h60, 5'b10000));
        // bad checksum frame, entered from RUN
        tbl.push_back(mk(L, H, 8'hA5, L, 8'h04, 8'h60, 5'b11100));
        tbl.push_back(mk(L, H, 8'h00, L, 8'h04, 8'h60, 5'b11100));
        tbl.push_back(mk(L, H, 8'h05, L, 8'h04, 8'h60, 5'b11100));
        tbl.push_back(mk(L, H, 8'h20, H, 8'h00, 8'h20, 5'b11100));
        tbl.push_back(mk(L, H, 8'h1F, H, 8'h01, 8'h1F, 5'b11100));
        tbl.push_back(mk(L, H, 8'h30, H, 8'h02, 8'h30, 5'b11100));
        tbl.push_back(mk(L, H, 8'h34, H, 8'h03, 8'h34, 5'b11100));
        tbl.push_back(mk(L, H, 8'h60, H, 8'h04, 8'h60, 5'b11100));
        tbl.push_back(mk(L, H, 8'h09, L, 8'h04, 8'h60, 5'b11001));
        tbl.push_back(mk(L, H, 8'h33, L, 8'h04, 8'h60, 5'b11001));
        tbl.push_back(mk(L, L, 8'h00, L, 8'h04, 8'h60, 5'b11001));
        // address wrap frame clears err
        tbl.push_back(mk(L, H, 8'hA5, L, 8'h04, 8'h60, 5'b11100));
        tbl.push_back(mk(L, H, 8'hFE, L, 8'h04, 8'h60, 5'b11100));
        tbl.push_back(mk(L, H, 8'h03, L, 8'h04, 8'h60, 5'b11100));
        tbl.push_back(mk(L, H, 8'h11, H, 8'hFE, 8'h11, 5'b11100));
        tbl.push_back(mk(L, H, 8'h22, H, 8'hFF, 8'h22, 5'b11100));
        tbl.push_back(mk(L, H, 8'h33, H, 8'h00, 8'h33, 5'b11100));
        tbl.push_back(mk(L, H, 8'h67, L, 8'h00, 8'h33, 5'b01110));
        tbl.push_back(mk(L, L, 8'h00, L, 8'h00, 8'h33, 5'b10000));
        tbl.push_back(mk(L, H, 8'h3C, L, 8'h00, 8'h33, 5'b10000));
        // HDR value inside a frame is plain payload
        tbl.push_back(mk(L, H, 8'hA5, L, 8'h00, 8'h33, 5'b11100));
        tbl.push_back(mk(L, H, 8'h00, L, 8'h00, 8'h33, 5'b11100));
        tbl.push_back(mk(L, H, 8'h01, L, 8'h00, 8'h33, 5'b11100));
        tbl.push_back(mk(L, H, 8'hA5, H, 8'h00, 8'hA5, 5'b11100));
        tbl.push_back(mk(L, H, 8'hA6, L, 8'h00, 8'hA5, 5'b01110));
        tbl.push_back(mk(L, L, 8'h00, L, 8'h00, 8'hA5, 5'b10000));
        // reset wins over an offered byte; then zero length with junk
        tbl.push_back(mk(H, H, 8'hA5, L, 8'h00, 8'h00, 5'b11000));
        tbl.push_back(mk(L, H, 8'h3C, L, 8'h00, 8'h00, 5'b11000));
        tbl.push_back(mk(L, H, 8'h77, L, 8'h00, 8'h00, 5'b11000));
        tbl.push_back(mk(L, H, 8'hA5, L, 8'h00, 8'h00, 5'b11100));
        tbl.push_back(mk(L, H, 8'h10, L, 8'h00, 8'h00, 5'b11100));
        tbl.push_back(mk(L, H, 8'h00, L, 8'h00, 8'h00, 5'b11100));
        tbl.push_back(mk(L, H, 8'h10, L, 8'h00, 8'h00, 5'b01110));
        tbl.push_back(mk(L, L, 8'h00, L, 8'h00, 8'h00, 5'b10000));

        foreach (tbl[i]) begin
            rst          = tbl[i].r;
            bus.in_valid = tbl[i].v;
            bus.in_data  = tbl[i].d;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;

        // good load with random stalls between bytes
        pulse_reset();
        wr_q.delete();
        done_cnt = 0;
        foreach (good[i]) send_byte(good[i], int'($urandom_range(0, 3)));
        k = 0;
        while (core_rst && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("stall_core_release", 32'(core_rst), 32'(0));
        check("stall_err", 32'(err), 32'(0));
        check("stall_done_count", 32'(done_cnt), 32'(1));
        check("stall_write_count", 32'(wr_q.size()), 32'(5));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_write%0d", i),
                  (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF, 32'(exp_wr[i]));
        end
        // reload from RUN: core goes back into reset right after the HDR
        send_byte(8'hA5, 0);
        check("reload_core_rst", 32'(core_rst), 32'(1));
        check("reload_busy", 32'(busy), 32'(1));

        // reset after the second payload byte
        pulse_reset();
        wr_q.delete();
        for (int i = 0; i < 5; i++) send_byte(good[i], 0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h30;
        @(posedge clk);
        #1;
        check("rst_mid_outputs", 32'(obs()), 32'({1'b0, 8'h00, 8'h00, 5'b11000}));
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_idle", 32'(obs()), 32'({1'b0, 8'h00, 8'h00, 5'b11000}));
        check("rst_mid_write_count", 32'(wr_q.size()), 32'(2));
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_mid_write%0d", i),
                  (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF, 32'(exp_wr[i]));
        end

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
